// File: rtl/beta_alu_pkg.sv
// Shared Beta ALU function codes, arbiter FSM states and decode helpers.
package beta_alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_MUL   = 4'b0010;
  localparam logic [3:0] ALU_CMPEQ = 4'b0100;
  localparam logic [3:0] ALU_CMPLT = 4'b0101;
  localparam logic [3:0] ALU_CMPLE = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b1000;
  localparam logic [3:0] ALU_OR    = 4'b1001;
  localparam logic [3:0] ALU_XOR   = 4'b1010;
  localparam logic [3:0] ALU_XNOR  = 4'b1011;
  localparam logic [3:0] ALU_SHL   = 4'b1100;
  localparam logic [3:0] ALU_SHR   = 4'b1101;
  localparam logic [3:0] ALU_SRA   = 4'b1110;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

  // Codes the ALU decodes as its default (add); flagged back to the requester.
  function automatic logic is_unsupported_fn(input logic [3:0] fn);
    return (fn == 4'b0011) || (fn == 4'b0111) || (fn == 4'b1111);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N  = 3,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/beta_alu_arbiter.sv
// Shares one combinational Beta ALU between NUM_REQ requesters, one operation in flight,
// with round-robin grant and a valid/ready response channel.
module beta_alu_arbiter
  import beta_alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned MUL_LAT = 2,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*4-1:0]  req_fn,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [3:0]            alu_fn,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  input  logic [31:0]           alu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err
);

  localparam logic [3:0] MulCnt = 4'(MUL_LAT - 1);

  arb_state_t state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d, id_q, id_d, rsp_id_q, rsp_id_d;
  logic [3:0]         cnt_q, cnt_d, fn_q, fn_d;
  logic [31:0]        a_q, a_d, b_q, b_d, rsp_data_q, rsp_data_d;
  logic               rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               any;
  logic [3:0]         sel_fn;
  logic [31:0]        sel_a, sel_b;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  assign sel_fn = req_fn[4*int'(grant_idx) +: 4];
  assign sel_a  = req_a[32*int'(grant_idx) +: 32];
  assign sel_b  = req_b[32*int'(grant_idx) +: 32];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    fn_d        = fn_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        if (any) begin
          req_ready = grant;
          fn_d      = sel_fn;
          a_d       = sel_a;
          b_d       = sel_b;
          id_d      = grant_idx;
          rr_ptr_d  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          cnt_d     = (sel_fn == ALU_MUL) ? MulCnt : 4'd0;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_data_d  = alu_result;
          rsp_id_d    = id_q;
          rsp_err_d   = is_unsupported_fn(fn_q);
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      fn_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      fn_q        <= fn_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign alu_fn    = fn_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_beta_alu_arbiter.sv
// Scoreboard bench for beta_alu_arbiter with a behavioural Beta ALU on the alu_* port.
module tb_beta_alu_arbiter;
  import beta_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid, req_ready;
  logic [11:0] req_fn;
  logic [95:0] req_a, req_b;
  logic [3:0]  alu_fn;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_data;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  beta_alu_arbiter #(
    .NUM_REQ (3),
    .MUL_LAT (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_fn     (req_fn),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_fn     (alu_fn),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  always_comb begin
    alu_result = alu_a + alu_b;
    case (alu_fn)
      ALU_SUB:   alu_result = alu_a - alu_b;
      ALU_MUL:   alu_result = alu_a * alu_b;
      ALU_CMPEQ: alu_result = {31'd0, alu_a == alu_b};
      ALU_CMPLT: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      ALU_CMPLE: alu_result = {31'd0, $signed(alu_a) <= $signed(alu_b)};
      ALU_AND:   alu_result = alu_a & alu_b;
      ALU_OR:    alu_result = alu_a | alu_b;
      ALU_XOR:   alu_result = alu_a ^ alu_b;
      ALU_XNOR:  alu_result = ~(alu_a ^ alu_b);
      ALU_SHL:   alu_result = alu_a << alu_b[4:0];
      ALU_SHR:   alu_result = alu_a >> alu_b[4:0];
      ALU_SRA:   alu_result = $signed(alu_a) >>> alu_b[4:0];
      default:   alu_result = alu_a + alu_b;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic push(input int id, input logic [31:0] data, input logic err);
    exp_t e;
    e.id   = 2'(id);
    e.data = data;
    e.err  = err;
    sb.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [3:0] fn, input logic [31:0] a,
                         input logic [31:0] b);
    req_fn[4*i +: 4]  = fn;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_valid[i]      = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles from a grant (called just after the grant edge) to rsp_valid.
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 40);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_outs"}, 64'({req_ready, rsp_valid, rsp_id, rsp_err, alu_fn}), 64'd0);
    check({name, "_data"}, 64'(rsp_data), 64'd0);
    check({name, "_alu_ab"}, {alu_a, alu_b}, 64'd0);
  endtask

  // Monitor: pop and compare whenever a response handshake is presented.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_id", 64'(rsp_id), 64'(e.id));
        check("rsp_data", 64'(rsp_data), 64'(e.data));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    logic [31:0] rr_data [3];
    rr_data[0] = 32'd99;
    rr_data[1] = 32'd108;
    rr_data[2] = 32'd117;

    rst_n = 1'b0; req_valid = '0; req_fn = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    step();
    rst_n = 1'b1;

    // Single ADD from requester 1: same-cycle grant, response two cycles later.
    set_req(1, ALU_ADD, 32'd5, 32'd7);
    @(negedge clk);
    check("t1_grant", 64'(req_ready), 64'(3'b010));
    push(1, 32'd12, 1'b0);
    step();
    req_valid[1] = 1'b0;
    wait_rsp(lat);
    check("t1_latency", 64'(lat), 64'd2);

    // MUL on requester 2 (rr_ptr=2) with a SUB parked on requester 0.
    step();
    set_req(2, ALU_MUL, 32'd6, 32'd7);
    set_req(0, ALU_SUB, 32'd50, 32'd9);
    @(negedge clk);
    check("t2_mul_grant", 64'(req_ready), 64'(3'b100));
    push(2, 32'd42, 1'b0);
    step();
    req_valid[2] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t2_alu_hold", {28'd0, alu_fn, alu_a}, {28'd0, ALU_MUL, 32'd6});
      check("t2_alu_b_hold", 64'(alu_b), 64'd7);
      check("t2_no_grant_exec", 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    check("t2_mul_latency", 64'(rsp_valid), 64'd1);
    check("t2_no_grant_resp", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("t2_sub_grant", 64'(req_ready), 64'(3'b001));
    push(0, 32'd41, 1'b0);
    step();
    req_valid[0] = 1'b0;
    wait_rsp(lat);
    check("t2_sub_latency", 64'(lat), 64'd2);

    // Backpressure on a CMPLT from requester 1 while requester 0 waits.
    step();
    rsp_ready = 1'b0;
    set_req(1, ALU_CMPLT, 32'd3, 32'd9);
    @(negedge clk);
    check("t3_grant", 64'(req_ready), 64'(3'b010));
    push(1, 32'd1, 1'b0);
    step();
    req_valid[1] = 1'b0;
    set_req(0, 4'b0111, 32'd1, 32'd2);
    wait_rsp(lat);
    check("t3_latency", 64'(lat), 64'd2);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      check("t3_stall_valid", 64'(rsp_valid), 64'd1);
      check("t3_stall_data", 64'(rsp_data), 64'd1);
      check("t3_stall_ready", 64'(req_ready), 64'd0);
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t4_idle_after_accept", 64'(req_ready), 64'(3'b001));
    // Unsupported code still runs the add and flags the error.
    push(0, 32'd3, 1'b1);
    step();
    req_valid[0] = 1'b0;
    wait_rsp(lat);
    check("t4_latency", 64'(lat), 64'd2);

    // Reset during EXEC of a MUL: dropped, no response, pointer returns to 0.
    step();
    set_req(1, ALU_MUL, 32'd3, 32'd4);
    @(negedge clk);
    check("t5_grant", 64'(req_ready), 64'(3'b010));
    step();
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("t5_reset");
    step();
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    check("t5_no_rsp", 64'(n), 64'd0);

    // Round-robin with all three requesters held high.
    step();
    for (int i = 0; i < 3; i++) set_req(i, ALU_SUB, 32'(100 + 10 * i), 32'(i + 1));
    for (int k = 0; k < 6; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (req_ready == 3'b000 && n < 20);
      check("t6_rr_grant", 64'(req_ready), 64'(3'b001 << (k % 3)));
      push(k % 3, rr_data[k % 3], 1'b0);
      step();
    end
    req_valid = '0;

    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    step();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/beta_alu_arbiter.md
Name: beta_alu_arbiter

Overview:
Shares one combinational Beta ALU (AluFn/InA/InB/Result) between NUM_REQ requesters, for example the integer pipe, the address-generation unit and the debug port. The block picks one request using a round-robin arbiter and registers that request's operands into the ALU. It holds the ALU inputs for a fixed number of execute cycles (longer for multiply), captures the result, and returns it with a valid/ready handshake. Only one operation is in flight at a time.

Parameters:
NUM_REQ, 3, number of requesters; legal range 2..8
MUL_LAT, 2, execute cycles for the MUL function (4'b0010); legal range 1..15; all other functions take 1 cycle
ID_W, $clog2(NUM_REQ), width of the requester index (derived; not overridden)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  request pending, one bit per requester
req_ready  out  NUM_REQ  one-hot grant/accept; at most one bit set
req_fn  in  NUM_REQ*4  AluFn for requester i, at bits [4i+3:4i]
req_a  in  NUM_REQ*32  operand A for requester i, at bits [32i+31:32i]
req_b  in  NUM_REQ*32  operand B for requester i
alu_fn  out  4  to the ALU's AluFn input
alu_a  out  32  to the ALU's InA input
alu_b  out  32  to the ALU's InB input
alu_result  in  32  from the ALU's Result output
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts the response
rsp_id  out  ID_W  index of the requester that owns the response
rsp_data  out  32  captured ALU result
rsp_err  out  1  AluFn was unsupported (4'b0011, 4'b0111 or 4'b1111)

Behaviour:
- Reset: rst_n low clears the block asynchronously.
  - state=IDLE, rr_ptr=0, exec counter=0.
  - alu_fn/alu_a/alu_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, req_ready=0.
  - An operation in flight when reset asserts is dropped and no response is produced.
  - Reset is released synchronously to clk.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If no req_valid bit is set, stay in IDLE and drive req_ready=0.
  - Otherwise grant g = the first set bit of req_valid, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready[g]=1 is combinational, in the same cycle. The handshake completes in that cycle.
  - On that clock edge:
    - latch fn/a/b into the ALU operand registers; latch g into the id register.
    - rr_ptr <= (g+1) mod NUM_REQ.
    - exec counter <= (fn==MUL) ? MUL_LAT-1 : 0.
    - next state = EXEC.
- EXEC:
  - alu_* hold the latched values and req_ready=0.
  - If the counter is nonzero, decrement it and stay in EXEC.
  - If the counter is zero:
    - rsp_data <= alu_result; rsp_id <= id.
    - rsp_err <= fn is in {0011, 0111, 1111}. The result is still captured for these codes.
    - rsp_valid <= 1; next state = RESP.
- RESP:
  - rsp_valid=1. rsp_data, rsp_id and rsp_err stay stable until accepted.
  - On rsp_ready=1: rsp_valid <= 0 and next state = IDLE.
  - With rsp_ready=0 the block stalls indefinitely. There is no timeout.
- Latency: the grant cycle is t. The response is visible at t+2 for non-MUL functions and t+1+MUL_LAT for MUL. Best-case throughput is one operation per 3 cycles.
- Requesters must keep req_valid and operands stable until they are granted. Deasserting req_valid before the grant is legal; that request is simply not granted.
- Simultaneous requests: round-robin gives starvation-free service. With all requests asserted continuously, grants go rr_ptr, rr_ptr+1, … in strict rotation.
- rr_ptr changes only on a grant. Idle cycles do not advance it.
- alu_* are registered outputs. Between operations they keep their last values; they are not cleared on return to IDLE.
- rsp_ready while rsp_valid=0 is ignored.
- Every AluFn value is forwarded unchanged. Unsupported codes run the ALU's default (add) and set rsp_err=1.

Decomposition:
- Shared package beta_alu_pkg, containing:
  - AluFn localparams: ALU_ADD=4'b0000, ALU_SUB=0001, ALU_MUL=0010, ALU_CMPEQ=0100, ALU_CMPLT=0101, ALU_CMPLE=0110, ALU_AND=1000, ALU_OR=1001, ALU_XOR=1010, ALU_XNOR=1011, ALU_SHL=1100, ALU_SHR=1101, ALU_SRA=1110.
  - Function is_unsupported_fn().
  - Enum arb_state_t {IDLE, EXEC, RESP}.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N], ptr[$clog2(N)].
  - Outputs: grant one-hot, grant_idx, any.
  - Purely combinational; reused by the later bus arbiter.

Test Plan:
- Reset then single request: rst_n released; requester 1 sends fn=0000, a=5, b=7 -> req_ready=3'b010 in the same cycle; 2 cycles later rsp_valid=1, rsp_id=1, rsp_data=12, rsp_err=0.
- Round-robin fairness: all three req_valid held high with fn=SUB, rsp_ready tied high -> grants in order 0,1,2,0,1,2; exactly one req_ready bit set per grant; each response carries the matching rsp_id.
- MUL latency (MUL_LAT=2): requester 2 sends fn=0010, a=6, b=7 -> alu_* stable for 2 cycles; rsp_data=42 at grant+3; a SUB request queued on requester 0 is not granted until the MUL response is accepted.
- Backpressure: rsp_ready=0 for 10 cycles after a CMPLT with a=3, b=9 -> rsp_valid stays 1, rsp_data=1 stable, req_ready=0 throughout; rsp_ready=1 -> IDLE next cycle.
- Unsupported fn: fn=4'b0111, a=1, b=2 -> rsp_err=1, rsp_data=3.
- Reset mid-op: rst_n pulsed low during EXEC -> all outputs 0 immediately; no rsp_valid after release; next grant starts from requester 0.
